// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: redirect/stall control in, ROM address/data, IF/ID payload out.
interface fetch_stage_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_instr;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [ILEN-1:0] ifid_instr;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_instr,
        output imem_addr, ifid_valid, ifid_pc, ifid_instr
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_instr,
        input  imem_addr, ifid_valid, ifid_pc, ifid_instr
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Halts permanently (until reset) on an illegal fetch or redirect address.
module fetch_stage #(
    parameter logic [63:0]  RESET_PC  = 64'd0,
    parameter int unsigned  IMEM_SIZE = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_stage_if.master      bus,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned CNTW = 32;
    // Upper bound rewritten as A < SIZE-3 so the check cannot overflow on huge addresses.
    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(IMEM_SIZE) - XLEN'(3);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
    logic [ILEN-1:0]   ifid_instr_q, ifid_instr_d;
    logic              fault_q, fault_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [XLEN-1:0]   pc_plus4;

    function automatic logic is_legal(input logic [XLEN-1:0] a);
        return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
    endfunction

    assign pc_plus4 = pc_q + XLEN'(4);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            fault_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            fault_q      <= fault_d;
            count_q      <= count_d;
        end
    end

    // Priority in RUN: redirect, then stall, then sequential fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        fault_d      = fault_q;
        count_d      = count_q;

        unique case (state_q)
            RUN: begin
                if (bus.redirect_valid) begin
                    ifid_valid_d = 1'b0;
                    if (is_legal(bus.redirect_target)) begin
                        pc_d = bus.redirect_target;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end else if (!bus.stall) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = bus.imem_instr;
                    ifid_valid_d = 1'b1;
                    count_d      = count_q + CNTW'(1);
                    if (is_legal(pc_plus4)) begin
                        pc_d = pc_plus4;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end
            end
            HALT: begin
                // A stalled valid entry is held until the consumer releases the stall.
                if (!bus.stall) begin
                    ifid_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign bus.imem_addr  = pc_q;
    assign bus.ifid_valid = ifid_valid_q;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign fetch_fault    = fault_q;
    assign fetch_count    = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus hand-written halt/reset sequences.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_fault;
    logic [31:0] fetch_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(64'd0), .IMEM_SIZE(1024)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .fetch_fault (fetch_fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        return {16'hE000, a[15:0]};
    endfunction

    // Combinational ROM model
    assign bus.imem_instr = rom(bus.imem_addr);

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        rv;
        logic [63:0] tgt;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [63:0] t,
                                input logic [63:0] a, input logic ev, input logic [63:0] p,
                                input logic f, input logic [31:0] c);
        vec_t x;
        x.rst_n = r; x.stall = s; x.rv = v; x.tgt = t;
        x.e_addr = a; x.e_valid = ev; x.e_pc = p; x.e_fault = f; x.e_cnt = c;
        x.e_instr = (c == 32'd0) ? 32'd0 : rom(p);
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [63:0] t);
        @(negedge clk);
        reset_n = r;
        bus.stall = s;
        bus.redirect_valid = v;
        bus.redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input int idx, input logic [63:0] a, input logic ev, input logic [63:0] p,
                              input logic [31:0] ins, input logic f, input logic [31:0] c);
        chk("imem_addr",   idx, bus.imem_addr, a);
        chk("ifid_valid",  idx, 64'(bus.ifid_valid), 64'(ev));
        chk("ifid_pc",     idx, bus.ifid_pc, p);
        chk("ifid_instr",  idx, 64'(bus.ifid_instr), 64'(ins));
        chk("fetch_fault", idx, 64'(fetch_fault), 64'(f));
        chk("fetch_count", idx, 64'(fetch_count), 64'(c));
    endtask

    initial begin
        reset_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;

        //            rst  stl  rv   tgt       addr      v    ifpc      flt  cnt
        vecs[0]  = mk(1'b0,1'b0,1'b0,64'h0,   64'h0,    1'b0,64'h0,   1'b0,32'd0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,64'h0,   64'h0,    1'b0,64'h0,   1'b0,32'd0);
        vecs[2]  = mk(1'b1,1'b0,1'b0,64'h0,   64'h4,    1'b1,64'h0,   1'b0,32'd1);
        vecs[3]  = mk(1'b1,1'b0,1'b0,64'h0,   64'h8,    1'b1,64'h4,   1'b0,32'd2);
        vecs[4]  = mk(1'b1,1'b1,1'b0,64'h0,   64'h8,    1'b1,64'h4,   1'b0,32'd2);
        vecs[5]  = mk(1'b1,1'b1,1'b0,64'h0,   64'h8,    1'b1,64'h4,   1'b0,32'd2);
        vecs[6]  = mk(1'b1,1'b0,1'b0,64'h0,   64'hC,    1'b1,64'h8,   1'b0,32'd3);
        vecs[7]  = mk(1'b1,1'b0,1'b0,64'h0,   64'h10,   1'b1,64'hC,   1'b0,32'd4);
        vecs[8]  = mk(1'b1,1'b0,1'b1,64'h40,  64'h40,   1'b0,64'hC,   1'b0,32'd4);
        vecs[9]  = mk(1'b1,1'b0,1'b0,64'h0,   64'h44,   1'b1,64'h40,  1'b0,32'd5);
        vecs[10] = mk(1'b1,1'b0,1'b0,64'h0,   64'h48,   1'b1,64'h44,  1'b0,32'd6);
        vecs[11] = mk(1'b1,1'b0,1'b1,64'h10,  64'h10,   1'b0,64'h44,  1'b0,32'd6);
        vecs[12] = mk(1'b1,1'b1,1'b1,64'h40,  64'h40,   1'b0,64'h44,  1'b0,32'd6);
        vecs[13] = mk(1'b1,1'b1,1'b0,64'h0,   64'h40,   1'b0,64'h44,  1'b0,32'd6);
        vecs[14] = mk(1'b1,1'b0,1'b0,64'h0,   64'h44,   1'b1,64'h40,  1'b0,32'd7);
        vecs[15] = mk(1'b1,1'b0,1'b1,64'h42,  64'h44,   1'b0,64'h40,  1'b1,32'd7);
        vecs[16] = mk(1'b1,1'b0,1'b1,64'h0,   64'h44,   1'b0,64'h40,  1'b1,32'd7);
        vecs[17] = mk(1'b1,1'b0,1'b0,64'h0,   64'h44,   1'b0,64'h40,  1'b1,32'd7);
        vecs[18] = mk(1'b0,1'b0,1'b0,64'h0,   64'h0,    1'b0,64'h0,   1'b0,32'd0);
        vecs[19] = mk(1'b1,1'b0,1'b0,64'h0,   64'h4,    1'b1,64'h0,   1'b0,32'd1);
        vecs[20] = mk(1'b1,1'b0,1'b1,64'h400, 64'h4,    1'b0,64'h0,   1'b1,32'd1);
        vecs[21] = mk(1'b1,1'b0,1'b1,64'h0,   64'h4,    1'b0,64'h0,   1'b1,32'd1);
        vecs[22] = mk(1'b0,1'b0,1'b0,64'h0,   64'h0,    1'b0,64'h0,   1'b0,32'd0);
        vecs[23] = mk(1'b1,1'b0,1'b0,64'h0,   64'h4,    1'b1,64'h0,   1'b0,32'd1);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst_n, vecs[i].stall, vecs[i].rv, vecs[i].tgt);
            expect_all(i, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc,
                       vecs[i].e_instr, vecs[i].e_fault, vecs[i].e_cnt);
        end

        // Run off the end of the ROM: last word at 0x3FC is latched, then HALT.
        step(1'b1, 1'b0, 1'b1, 64'h3F0);
        expect_all(100, 64'h3F0, 1'b0, 64'h0, rom(64'h0), 1'b0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 64'h0);
            expect_all(101 + k, 64'h3F4 + 64'(4 * k), 1'b1, 64'h3F0 + 64'(4 * k),
                       rom(64'h3F0 + 64'(4 * k)), 1'b0, 32'(2 + k));
        end
        step(1'b1, 1'b0, 1'b0, 64'h0);
        expect_all(110, 64'h3FC, 1'b1, 64'h3FC, rom(64'h3FC), 1'b1, 32'd5);
        // Stalled valid entry survives in HALT, then clears once stall drops.
        step(1'b1, 1'b1, 1'b1, 64'h0);
        expect_all(111, 64'h3FC, 1'b1, 64'h3FC, rom(64'h3FC), 1'b1, 32'd5);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        expect_all(112, 64'h3FC, 1'b0, 64'h3FC, rom(64'h3FC), 1'b1, 32'd5);
        // Reset while halted and stalled.
        step(1'b0, 1'b1, 1'b1, 64'h40);
        expect_all(113, 64'h0, 1'b0, 64'h0, 32'h0, 1'b0, 32'd0);

        // Reset during an active stall in RUN.
        step(1'b1, 1'b0, 1'b0, 64'h0);
        expect_all(120, 64'h4, 1'b1, 64'h0, rom(64'h0), 1'b0, 32'd1);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        expect_all(121, 64'h8, 1'b1, 64'h4, rom(64'h4), 1'b0, 32'd2);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        expect_all(122, 64'h8, 1'b1, 64'h4, rom(64'h4), 1'b0, 32'd2);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        expect_all(123, 64'h0, 1'b0, 64'h0, 32'h0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        expect_all(124, 64'h4, 1'b1, 64'h0, rom(64'h0), 1'b0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
